blink_controller: RTL and testbench

Sequencing controller for a bank of toggle-type blinker cells. A blinker inverts its registered output on every clock where its `switch` input is high. This block drives each blinker's `switch` with registered single-cycle pulses from a shared beat timebase and a per-channel mode register, and reads back each blinker's `out` to force steady ON/OFF levels. It sits between the debounced front-panel buttons and the blinker instances.

---
 rtl/blink_controller.sv | 84 ++++++++
 tb/tb_blink_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/blink_controller.sv
// Sequencing controller for a bank of toggle-type blinker cells: per-channel mode
// registers, a shared beat prescaler, and registered single-cycle switch pulses.
module blink_controller #(
   parameter int N        = 4,
   parameter int BEAT_DIV = 1000000,
   parameter int SEL_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             next_btn,
   input  logic             sel_btn,
   input  logic [N-1:0]     blink_out,
   output logic [N-1:0]     switch,
   output logic [SEL_W-1:0] sel,
   output logic [1:0]       sel_mode,
   output logic             beat
);

   localparam int CNT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BEAT_DIV - 2);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_ON   = 2'd1,
      MODE_SLOW = 2'd2,
      MODE_FAST = 2'd3
   } mode_t;

   mode_t            mode [N];
   logic [CNT_W-1:0] cnt;
   logic [1:0]       slow_cnt;
   logic [N-1:0]     req;

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_OFF:  next_mode = MODE_ON;
         MODE_ON:   next_mode = MODE_SLOW;
         MODE_SLOW: next_mode = MODE_FAST;
         default:   next_mode = MODE_OFF;
      endcase
   endfunction

   assign sel_mode = mode[sel];

   // A channel that pulsed this cycle has not yet seen its blinker flip, so its
   // next request is held off to avoid a double toggle.
   always_comb begin
      req = '0;
      for (int i = 0; i < N; i++) begin
         case (mode[i])
            MODE_OFF:  req[i] = blink_out[i];
            MODE_ON:   req[i] = ~blink_out[i];
            MODE_SLOW: req[i] = beat && (slow_cnt == 2'd3);
            MODE_FAST: req[i] = beat;
            default:   req[i] = 1'b0;
         endcase
         if (switch[i]) req[i] = 1'b0;
      end
   end

   // beat is registered one count early so it lines up with cnt == BEAT_DIV-1
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) mode[i] <= MODE_OFF;
         sel      <= '0;
         cnt      <= '0;
         slow_cnt <= 2'd0;
         switch   <= '0;
         beat     <= 1'b0;
      end else begin
         cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         beat   <= (cnt == CNT_PRE);
         switch <= req;
         if (beat) slow_cnt <= slow_cnt + 2'd1;
         if (sel_btn) sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
         for (int i = 0; i < N; i++) begin
            if (next_btn && (sel == SEL_W'(i))) mode[i] <= next_mode(mode[i]);
         end
      end
   end

endmodule

// File: tb/tb_blink_controller.sv
// Directed bench for blink_controller with four toggle-blinker models on the outputs.
module tb_blink_controller;

   logic       clk;
   logic       rst;
   logic       next_btn;
   logic       sel_btn;
   logic [3:0] bo;
   logic [3:0] sw;
   logic [1:0] sel;
   logic [1:0] sel_mode;
   logic       beat;

   logic       beat_d;
   logic [3:0] bo_d;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int m_np, m_bad_int, m_bad_ph, m_nrise, m_bad_rise, m_first, m_both, m_other;

   blink_controller #(.N(4), .BEAT_DIV(4), .SEL_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .next_btn  (next_btn),
      .sel_btn   (sel_btn),
      .blink_out (bo),
      .switch    (sw),
      .sel       (sel),
      .sel_mode  (sel_mode),
      .beat      (beat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // toggle blinkers sharing the controller reset
   always @(posedge clk) begin
      if (rst) bo <= '0;
      else     bo <= bo ^ sw;
      beat_d <= beat;
      bo_d   <= bo;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Watch channel ch for n cycles; per is the expected pulse spacing.
   task automatic mon(input int n, input int ch, input int per);
      int last_p;
      int last_r;
      last_p = -1; last_r = -1;
      m_np = 0; m_bad_int = 0; m_bad_ph = 0; m_nrise = 0; m_bad_rise = 0;
      m_first = -1; m_both = 0; m_other = 0;
      for (int k = 0; k < n; k++) begin
         if (sw[ch]) begin
            m_np++;
            if (m_first < 0) m_first = cyc;
            if (last_p >= 0 && (cyc - last_p) != per) m_bad_int++;
            if (!beat_d || (cyc % per) != 0) m_bad_ph++;
            if (sw[0] && sw[1]) m_both++;
            last_p = cyc;
         end
         if ((sw & ~(4'b0001 << ch)) != 4'b0000) m_other++;
         if (bo[ch] && !bo_d[ch]) begin
            m_nrise++;
            if (last_r >= 0 && (cyc - last_r) != 2 * per) m_bad_rise++;
            last_r = cyc;
         end
         tick();
      end
   endtask

   initial begin
      int first_beat, nbeat, bad_beat, npulse, k, t;
      rst = 1'b1; next_btn = 1'b0; sel_btn = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      cyc = 0;

      // reset state and beat timebase
      chk("rst_switch", sw, 0);
      chk("rst_sel", sel, 0);
      chk("rst_sel_mode", sel_mode, 0);
      chk("rst_beat", beat, 0);
      first_beat = -1; nbeat = 0; bad_beat = 0; npulse = 0;
      for (int j = 0; j < 20; j++) begin
         if (beat) begin
            nbeat++;
            if (first_beat < 0) first_beat = cyc;
            if (cyc % 4 != 3) bad_beat++;
         end else if (cyc % 4 == 3) bad_beat++;
         if (sw != 4'b0000) npulse++;
         tick();
      end
      chk("beat_first", first_beat, 3);
      chk("beat_count", nbeat, 5);
      chk("beat_spacing", bad_beat, 0);
      chk("idle_pulses", npulse, 0);

      // channel 0 -> ON
      next_btn = 1'b1; tick(); next_btn = 1'b0;
      chk("on_sel_mode", sel_mode, 1);
      mon(42, 0, 4);
      chk("on_pulses", m_np, 1);
      chk("on_pulse_cycle", m_first, 22);
      chk("on_other_ch", m_other, 0);
      chk("on_level", bo[0], 1);

      // channel 0 -> SLOW -> FAST (button held two cycles)
      next_btn = 1'b1; tick(); tick(); next_btn = 1'b0;
      chk("fast_sel_mode", sel_mode, 3);
      repeat (3) tick();
      mon(40, 0, 4);
      chk("fast_pulses", m_np, 10);
      chk("fast_interval", m_bad_int, 0);
      chk("fast_phase", m_bad_ph, 0);
      chk("fast_rises", m_nrise, 5);
      chk("fast_period", m_bad_rise, 0);

      // channel 1 -> SLOW
      sel_btn = 1'b1; tick(); sel_btn = 1'b0;
      chk("sel_one", sel, 1);
      chk("ch1_mode_off", sel_mode, 0);
      next_btn = 1'b1; tick(); tick(); next_btn = 1'b0;
      chk("slow_sel_mode", sel_mode, 2);
      tick(); tick();
      mon(64, 1, 16);
      chk("slow_pulses", m_np, 4);
      chk("slow_interval", m_bad_int, 0);
      chk("slow_phase", m_bad_ph, 0);
      chk("slow_fast_same_cycle", m_both, 4);

      // select wrap with a held button: 1->2->3->0 then four more back to 0
      sel_btn = 1'b1;
      tick(); chk("wrap_sel2", sel, 2);
      tick(); chk("wrap_sel3", sel, 3);
      tick(); chk("wrap_sel0", sel, 0);
      repeat (4) tick();
      sel_btn = 1'b0;
      chk("wrap_full", sel, 0);

      // both buttons while channel 0 (FAST) is high, away from its beat pulse
      k = 0;
      while (!((cyc % 4 == 1) && bo[0]) && k < 16) begin
         tick();
         k++;
      end
      chk("align_found", int'((cyc % 4 == 1) && bo[0]), 1);
      t = cyc;
      next_btn = 1'b1; sel_btn = 1'b1; tick(); next_btn = 1'b0; sel_btn = 1'b0;
      chk("both_sel", sel, 1);
      chk("both_sel_mode", sel_mode, 2);
      mon(30, 0, 4);
      chk("off_pulses", m_np, 1);
      chk("off_pulse_cycle", m_first, t + 2);
      chk("off_level", bo[0], 0);

      // reset during an active switch pulse on channel 1
      k = 0;
      while (!sw[1] && k < 24) begin
         tick();
         k++;
      end
      chk("pulse_found", sw[1], 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_switch", sw, 0);
      chk("midrst_beat", beat, 0);
      chk("midrst_sel", sel, 0);
      chk("midrst_levels", bo, 0);
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_sel", sel, i);
         chk("post_rst_mode", sel_mode, 0);
         sel_btn = 1'b1; tick(); sel_btn = 1'b0;
      end
      chk("post_rst_wrap", sel, 0);
      npulse = 0;
      repeat (12) begin
         if (sw != 4'b0000) npulse++;
         tick();
      end
      chk("post_rst_quiet", npulse, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
